// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_pkg
//  Description : Shared constants and types for the even-BCD counter display:
//                active-high seven-segment patterns (seg[0]=a .. seg[6]=g),
//                the digit-index type used by the scan logic and the default
//                prescaler divisors.
//  Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Which of the three digits is currently being driven.
  typedef enum logic [1:0] {
    DIG_UNITS    = 2'd0,
    DIG_TENS     = 2'd1,
    DIG_HUNDREDS = 2'd2
  } digit_idx_t;

  localparam int unsigned DEF_COUNT_DIV = 10;
  localparam int unsigned DEF_SCAN_DIV  = 4;

endpackage
`default_nettype wire

// File: rtl/bcd_to_7seg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_to_7seg
//  Description : 4-bit BCD to active-high seven-segment pattern. Non-BCD
//                codes blank the digit.
//  Ports       : bcd_i [3:0] - BCD digit
//                seg_o [6:0] - active-high pattern, seg_o[0]=a .. seg_o[6]=g
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/even_bcd_counter_display.sv
`default_nettype none
// ============================================================================
//  Module      : even_bcd_counter_display
//  Description : 3-digit BCD counter stepping by two (000..998, wrapping),
//                paced by an enable-gated prescaler, shown on a
//                time-multiplexed 3-digit seven-segment display with
//                selectable common-cathode / common-anode polarity.
//  Ports       : clk       - system clock, rising edge
//                rst_n     - synchronous reset, ACTIVE HIGH despite the name
//                en        - count enable (freezes count and its prescaler)
//                cathod    - 1 = common-cathode, 0 = common-anode
//                seg[6:0]  - segment drive (a=bit0), polarity per cathod
//                an[2:0]   - digit select: units, tens, hundreds
//                dp        - decimal point, always off
//                other_an  - unused board digit selects, always off
//                units/tens/hundreds - raw BCD digits for debug
//  Revision    : 1.0 - initial release
// ============================================================================
module even_bcd_counter_display
  import display_pkg::*;
#(
  parameter int unsigned COUNT_DIV = DEF_COUNT_DIV,
  parameter int unsigned SCAN_DIV  = DEF_SCAN_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       cathod,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       dp,
  output logic [4:0] other_an,
  output logic [3:0] units,
  output logic [3:0] tens,
  output logic [3:0] hundreds
);

  // A divisor of 1 still needs a 1-bit counter that never leaves zero.
  localparam int unsigned CNT_W  = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam int unsigned SCAN_W = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(COUNT_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  digit_idx_t        scan_idx_q, scan_idx_d;
  logic [3:0]        units_q, units_d;
  logic [3:0]        tens_q, tens_d;
  logic [3:0]        hundreds_q, hundreds_d;
  logic              step;
  logic [3:0]        sel_digit;
  logic [2:0]        sel_onehot;
  logic [6:0]        pattern;

  // Count prescaler and BCD step
  always_comb begin
    step       = en && (cnt_q == CNT_MAX);
    cnt_d      = cnt_q;
    units_d    = units_q;
    tens_d     = tens_q;
    hundreds_d = hundreds_q;

    if (en) begin
      cnt_d = step ? '0 : cnt_q + CNT_W'(1);
    end

    if (step) begin
      if (units_q == 4'd8) begin
        units_d = 4'd0;
        if (tens_q == 4'd9) begin
          tens_d = 4'd0;
          // 998 -> 000: hundreds rolls over with no carry-out.
          hundreds_d = (hundreds_q == 4'd9) ? 4'd0 : hundreds_q + 4'd1;
        end else begin
          tens_d = tens_q + 4'd1;
        end
      end else begin
        units_d = units_q + 4'd2;
      end
    end
  end

  // Free-running display scan, independent of en
  always_comb begin
    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == SCAN_MAX) begin
      scan_cnt_d = '0;
      case (scan_idx_q)
        DIG_UNITS: scan_idx_d = DIG_TENS;
        DIG_TENS:  scan_idx_d = DIG_HUNDREDS;
        default:   scan_idx_d = DIG_UNITS;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      cnt_q      <= '0;
      scan_cnt_q <= '0;
      scan_idx_q <= DIG_UNITS;
      units_q    <= 4'd0;
      tens_q     <= 4'd0;
      hundreds_q <= 4'd0;
    end else begin
      cnt_q      <= cnt_d;
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      units_q    <= units_d;
      tens_q     <= tens_d;
      hundreds_q <= hundreds_d;
    end
  end

  // Digit mux
  always_comb begin
    sel_digit  = units_q;
    sel_onehot = 3'b001;
    case (scan_idx_q)
      DIG_UNITS: begin
        sel_digit  = units_q;
        sel_onehot = 3'b001;
      end
      DIG_TENS: begin
        sel_digit  = tens_q;
        sel_onehot = 3'b010;
      end
      default: begin
        sel_digit  = hundreds_q;
        sel_onehot = 3'b100;
      end
    endcase
  end

  bcd_to_7seg u_dec (
    .bcd_i (sel_digit),
    .seg_o (pattern)
  );

  // Common-cathode drives segments high and digit selects low; common-anode
  // is the exact inverse. "Off" for dp/other_an follows the same rule.
  assign seg      = cathod ? pattern : ~pattern;
  assign an       = cathod ? ~sel_onehot : sel_onehot;
  assign dp       = ~cathod;
  assign other_an = {5{cathod}};

  assign units    = units_q;
  assign tens     = tens_q;
  assign hundreds = hundreds_q;

endmodule
`default_nettype wire

// File: tb/tb_even_bcd_counter_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_even_bcd_counter_display
//  Description : Directed self-checking bench for even_bcd_counter_display
//                (COUNT_DIV=10, SCAN_DIV=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_even_bcd_counter_display;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       cathod;
  logic [6:0] seg;
  logic [2:0] an;
  logic       dp;
  logic [4:0] other_an;
  logic [3:0] units;
  logic [3:0] tens;
  logic [3:0] hundreds;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;   // clock edges since last reset release

  logic [6:0] seg_tbl [10];

  even_bcd_counter_display #(
    .COUNT_DIV (10),
    .SCAN_DIV  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .cathod   (cathod),
    .seg      (seg),
    .an       (an),
    .dp       (dp),
    .other_an (other_an),
    .units    (units),
    .tens     (tens),
    .hundreds (hundreds)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc = cyc + 1;
    end
    #1;
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_val(input string tag, input int h, input int t, input int u);
    check({tag, "_hundreds"}, {8'd0, hundreds}, 12'(h));
    check({tag, "_tens"},     {8'd0, tens},     12'(t));
    check({tag, "_units"},    {8'd0, units},    12'(u));
  endtask

  initial begin
    int idx;
    int dig;
    logic [2:0] oh;

    seg_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Reset, common-anode
    rst_n  = 1'b1;
    en     = 1'b0;
    cathod = 1'b0;
    tick(3);
    check_val("reset", 0, 0, 0);
    check("reset_an",       {9'd0, an},       12'h001);
    check("reset_seg",      {5'd0, seg},      12'h040);
    check("reset_dp",       {11'd0, dp},      12'h001);
    check("reset_other_an", {7'd0, other_an}, 12'h000);

    // First steps
    rst_n = 1'b0;
    en    = 1'b1;
    cyc   = 0;
    tick(9);
    check("pre_first_step_units", {8'd0, units}, 12'd0);
    tick(1);
    check("first_step_units", {8'd0, units}, 12'd2);
    tick(10);
    check("second_step_units", {8'd0, units}, 12'd4);
    tick(30);
    check_val("val010", 0, 1, 0);

    // Enable hold mid-prescale: 5 cycles in, pause 37, then 5 more to step
    tick(5);
    en = 1'b0;
    tick(37);
    check_val("hold", 0, 1, 0);
    en = 1'b1;
    tick(4);
    check_val("resume_pre", 0, 1, 0);
    tick(1);
    check_val("resume_step", 0, 1, 2);

    // Count to 246: 117 more steps
    tick(1170);
    check_val("val246", 2, 4, 6);
    en = 1'b0;

    // Align to a scan-slot boundary, then walk four slots checking both polarities
    while ((cyc % 4) != 0) tick(1);
    for (int s = 0; s < 4; s++) begin
      idx = (cyc / 4) % 3;
      dig = (idx == 0) ? 6 : (idx == 1) ? 4 : 2;
      oh  = 3'b001 << idx;
      cathod = 1'b0;
      #1;
      check("scan_ca_an",  {9'd0, an},  {9'd0, oh});
      check("scan_ca_seg", {5'd0, seg}, {5'd0, ~seg_tbl[dig]});
      cathod = 1'b1;
      #1;
      check("scan_cc_an",       {9'd0, an},       {9'd0, ~oh});
      check("scan_cc_seg",      {5'd0, seg},      {5'd0, seg_tbl[dig]});
      check("scan_cc_dp",       {11'd0, dp},      12'h000);
      check("scan_cc_other_an", {7'd0, other_an}, 12'h01F);
      cathod = 1'b0;
      tick(4);
    end
    check_val("scan_hold", 2, 4, 6);

    // Mid-operation reset
    en    = 1'b1;
    rst_n = 1'b1;
    tick(1);
    check_val("midreset", 0, 0, 0);
    check("midreset_an",  {9'd0, an},  12'h001);
    check("midreset_seg", {5'd0, seg}, 12'h040);
    rst_n = 1'b0;
    cyc   = 0;
    tick(10);
    check_val("restart_step", 0, 0, 2);

    // Wrap: 498 further steps reach 998, next step wraps to 000
    tick(4980);
    check_val("val998", 9, 9, 8);
    tick(9);
    check_val("val998_hold", 9, 9, 8);
    tick(1);
    check_val("wrap000", 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/even_bcd_counter_display.md
Name: even_bcd_counter_display

Overview:
- 3-digit BCD counter that counts even numbers only: 000, 002, ..., 998, then wraps to 000.
- Advance is gated by `en` and paced by a clock-enable prescaler.
- The value drives a time-multiplexed 3-digit 7-segment display; `cathod` selects common-cathode or common-anode output polarity.
- Sits at board top level, between the clock/reset/switch inputs and the display pins; the raw BCD digits are also exported for debug.

Parameters:
- COUNT_DIV, 10: clk cycles (with `en` high) per +2 count step; legal range ≥1.
- SCAN_DIV, 4: clk cycles per display digit slot; legal range ≥1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-high reset. The name is kept per codebase; rst_n=1 resets.
- en  in  1  count enable; 0 freezes the count and its prescaler.
- cathod  in  1  display type: 1 = common-cathode, 0 = common-anode.
- seg  out  7  segment drive, seg[0]=a … seg[6]=g, polarity per `cathod`.
- an  out  3  digit select, one-hot-active: an[0]=units, an[1]=tens, an[2]=hundreds.
- dp  out  1  decimal point, always in the off state.
- other_an  out  5  unused digit selects of the 8-digit board, always in the off state.
- units  out  4  BCD units digit, always in {0,2,4,6,8}.
- tens  out  4  BCD tens digit, 0–9.
- hundreds  out  4  BCD hundreds digit, 0–9.

Behaviour:
- Reset (rst_n=1 at a clk edge): units, tens and hundreds = 0; count prescaler = 0; scan prescaler = 0; scan index = 0 (units).
- Count prescaler:
  - Increments only on cycles with en=1.
  - When it reaches COUNT_DIV-1 with en=1, it returns to 0 and a step fires.
  - With en=1 continuously after reset release, the first step is visible COUNT_DIV cycles after release.
- Step:
  - units += 2.
  - If units was 8: units=0 and tens+1.
  - If tens was also 9: tens=0 and hundreds+1.
  - If hundreds was also 9 (value 998): all digits return to 0, i.e. wrap to 000.
  - No carry-out port.
- en=0: digits and count prescaler hold. Display scanning continues.
- Reset overrides en and any pending step.
- Scan:
  - Free-running prescaler of SCAN_DIV cycles, independent of en.
  - Scan index cycles 0→1→2→0; index 3 is never reached.
  - The selected digit is shown for SCAN_DIV cycles.
- Segment decode, active-high form (a=bit0):
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
  - Any other code gives 0x00 (blank).
- Polarity, applied combinationally from `cathod`; a change takes effect the same cycle:
  - cathod=1: seg = active-high pattern; an active-low (selected bit 0, others 1); dp=0; other_an=5'b11111.
  - cathod=0: seg = inverted pattern (active-low); an active-high (selected bit 1, others 0); dp=1; other_an=5'b00000.
- Output timing: seg/an are combinational from registered digits and the scan index.
  - During and right after reset, with cathod=0: an=3'b001, seg=~0x3F=7'b1000000.

Decomposition:
- Shared package `display_pkg`:
  - the 10 seven-segment constants;
  - the digit-index typedef (2-bit);
  - default COUNT_DIV and SCAN_DIV.
- One natural sub-module: `bcd_to_7seg` (4-bit BCD in, 7-bit active-high pattern out).
- Counter, prescalers, scan mux and polarity logic live in the top.

Test Plan:
- Reset: hold rst_n=1 for 3 cycles, cathod=0 → units/tens/hundreds=0, an=3'b001, seg=7'b1000000, dp=1, other_an=0.
- First steps: release reset with en=1, COUNT_DIV=10 → units=2 after 10 cycles, 4 after 20; after 50 cycles the value is 010 (tens=1, units=0).
- Wrap: COUNT_DIV=1, en=1 → 499 cycles after release the value is 998; the next cycle gives 000.
- Enable hold: deassert en for 37 cycles mid-count → digits and prescaler unchanged; on reassert, the next step lands exactly where it would have with the pause removed.
- Scan/polarity:
  - SCAN_DIV=4 gives the an sequence 001,010,100,001 every 4 cycles, with seg matching the selected digit's pattern.
  - Toggling cathod=1 the same cycle inverts seg, gives an=~onehot, dp=0, other_an=5'b11111.
- Mid-operation reset: assert rst_n=1 at count 246 → next edge gives 000 and scan index 0; counting resumes from 000 on release.
